// File: rtl/seq_alu_pkg.sv
// Shared select codes and FSM state encoding for seq_alu and its iterative core.
// SEQ_ALU_SIGNED_EN adds the FIX state used for signed result fix-up.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_ADDN  = 4'd4;
  localparam logic [3:0] ALU_ZERO  = 4'd5;
  localparam logic [3:0] ALU_XOR   = 4'd6;
  localparam logic [3:0] ALU_ANDN  = 4'd7;
  localparam logic [3:0] ALU_MULTU = 4'd8;
  localparam logic [3:0] ALU_DIVU  = 4'd9;
  localparam logic [3:0] ALU_MULT  = 4'd10;
  localparam logic [3:0] ALU_DIV   = 4'd11;

`ifdef SEQ_ALU_SIGNED_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
`endif

endpackage

// File: rtl/seq_alu_muldiv.sv
// muldiv_iter: WIDTH-step unsigned shift-add multiplier / restoring divider.
// done and hi/lo are combinational: they show the result of the step taken at the next edge.
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic             r_active;
  logic             r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_hi_next;
  logic [WIDTH-1:0] w_lo_next;

  // Multiply keeps the multiplier in r_lo and shifts the product in from the top;
  // divide keeps the dividend in r_lo and shifts quotient bits in from the bottom.
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_b};
    if (!r_op) begin
      w_hi_next = w_sum[WIDTH:1];
      w_lo_next = {w_sum[0], r_lo[WIDTH-1:1]};
    end else if (!w_diff[WIDTH]) begin
      w_hi_next = w_diff[WIDTH-1:0];
      w_lo_next = {r_lo[WIDTH-2:0], 1'b1};
    end else begin
      w_hi_next = w_shift[WIDTH-1:0];
      w_lo_next = {r_lo[WIDTH-2:0], 1'b0};
    end
  end

  assign done = r_active && (r_cnt == CNT_W'(WIDTH - 1));
  assign hi   = w_hi_next;
  assign lo   = w_lo_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active <= 1'b0;
      r_op     <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
    end else if (go) begin
      r_active <= 1'b1;
      r_op     <= op;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= a;
      r_b      <= b;
    end else if (r_active) begin
      r_hi  <= w_hi_next;
      r_lo  <= w_lo_next;
      r_cnt <= r_cnt + 1'b1;
      if (done) r_active <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with iterative MULTU/DIVU and a start/busy/done handshake.
// Define SEQ_ALU_SIGNED_EN to enable signed MULT (10) and DIV (11).
module seq_alu
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       select,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_y, r_hi, r_lo;
  logic             r_zero, r_done, r_dbz;

  logic             w_accept, w_go, w_op_div, w_load_y, w_wr_hl, w_done_next, w_dbz_set;
  logic [WIDTH-1:0] w_y_next, w_hi_new, w_lo_new, w_core_a, w_core_b;
  logic             w_core_done;
  logic [WIDTH-1:0] w_core_hi, w_core_lo;

`ifdef SEQ_ALU_SIGNED_EN
  logic               r_signed, r_sdiv, r_neg_lo, r_neg_hi;
  logic [WIDTH-1:0]   r_raw_hi, r_raw_lo;
  logic               w_set_signed, w_set_sdiv;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_fix_hi, w_fix_lo;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;

  assign w_a_mag = a[WIDTH-1] ? -a : a;
  assign w_b_mag = b[WIDTH-1] ? -b : b;

  always_comb begin
    w_prod     = {r_raw_hi, r_raw_lo};
    w_prod_fix = r_neg_lo ? -w_prod : w_prod;
    if (r_sdiv) begin
      w_fix_lo = r_neg_lo ? -r_raw_lo : r_raw_lo;
      w_fix_hi = r_neg_hi ? -r_raw_hi : r_raw_hi;
    end else begin
      w_fix_lo = w_prod_fix[WIDTH-1:0];
      w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
    end
  end
`endif

  always_comb begin
    case (select)
      ALU_ADD:  w_y_next = a + b;
      ALU_SUB:  w_y_next = a - b;
      ALU_AND:  w_y_next = a & b;
      ALU_OR:   w_y_next = a | b;
      ALU_ADDN: w_y_next = a + ~b;
      ALU_XOR:  w_y_next = a ^ b;
      ALU_ANDN: w_y_next = a & ~b;
      default:  w_y_next = '0;
    endcase
  end

  assign w_accept = (r_state == IDLE) && start;

  always_comb begin
    w_state_next = r_state;
    w_go         = 1'b0;
    w_op_div     = 1'b0;
    w_load_y     = 1'b0;
    w_wr_hl      = 1'b0;
    w_done_next  = 1'b0;
    w_dbz_set    = 1'b0;
    w_hi_new     = w_core_hi;
    w_lo_new     = w_core_lo;
    w_core_a     = a;
    w_core_b     = b;
`ifdef SEQ_ALU_SIGNED_EN
    w_set_signed = 1'b0;
    w_set_sdiv   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
          case (select)
            ALU_MULTU: begin
              w_go         = 1'b1;
              w_state_next = MUL;
            end
            ALU_DIVU: begin
              if (b == '0) begin
                w_wr_hl     = 1'b1;
                w_hi_new    = a;
                w_lo_new    = '1;
                w_dbz_set   = 1'b1;
                w_done_next = 1'b1;
              end else begin
                w_go         = 1'b1;
                w_op_div     = 1'b1;
                w_state_next = DIV;
              end
            end
`ifdef SEQ_ALU_SIGNED_EN
            ALU_MULT: begin
              w_go         = 1'b1;
              w_core_a     = w_a_mag;
              w_core_b     = w_b_mag;
              w_set_signed = 1'b1;
              w_state_next = MUL;
            end
            ALU_DIV: begin
              if (b == '0) begin
                w_wr_hl     = 1'b1;
                w_hi_new    = a;
                w_lo_new    = '1;
                w_dbz_set   = 1'b1;
                w_done_next = 1'b1;
              end else begin
                w_go         = 1'b1;
                w_op_div     = 1'b1;
                w_core_a     = w_a_mag;
                w_core_b     = w_b_mag;
                w_set_signed = 1'b1;
                w_set_sdiv   = 1'b1;
                w_state_next = DIV;
              end
            end
`endif
            default: begin
              w_load_y    = 1'b1;
              w_done_next = 1'b1;
            end
          endcase
        end
      end
      MUL, DIV: begin
        if (w_core_done) begin
`ifdef SEQ_ALU_SIGNED_EN
          if (r_signed) begin
            w_state_next = FIX;
          end else begin
            w_wr_hl      = 1'b1;
            w_done_next  = 1'b1;
            w_state_next = IDLE;
          end
`else
          w_wr_hl      = 1'b1;
          w_done_next  = 1'b1;
          w_state_next = IDLE;
`endif
        end
      end
`ifdef SEQ_ALU_SIGNED_EN
      FIX: begin
        w_wr_hl      = 1'b1;
        w_hi_new     = w_fix_hi;
        w_lo_new     = w_fix_lo;
        w_done_next  = 1'b1;
        w_state_next = IDLE;
      end
`endif
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_y    <= '0;
      r_zero <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      if (w_load_y) begin
        r_y    <= w_y_next;
        r_zero <= (w_y_next == '0);
      end
      if (w_wr_hl) begin
        r_hi <= w_hi_new;
        r_lo <= w_lo_new;
      end
      r_done <= w_done_next;
      if (w_accept) r_dbz <= w_dbz_set;
    end
  end

`ifdef SEQ_ALU_SIGNED_EN
  // Result signs are decided from the original operands at acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_signed <= 1'b0;
      r_sdiv   <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_raw_hi <= '0;
      r_raw_lo <= '0;
    end else begin
      if (w_go) begin
        r_signed <= w_set_signed;
        r_sdiv   <= w_set_sdiv;
        r_neg_lo <= a[WIDTH-1] ^ b[WIDTH-1];
        r_neg_hi <= a[WIDTH-1];
      end
      if (w_core_done) begin
        r_raw_hi <= w_core_hi;
        r_raw_lo <= w_core_lo;
      end
    end
  end
`endif

  muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .go    (w_go),
    .op    (w_op_div),
    .a     (w_core_a),
    .b     (w_core_b),
    .done  (w_core_done),
    .hi    (w_core_hi),
    .lo    (w_core_lo)
  );

  assign y           = r_y;
  assign zero        = r_zero;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;

endmodule
